// File: rtl/mlp_pkg.sv
// Shared sizing, FSM encodings and weight decode for the binary-input MLP sequencer.
package mlp_pkg;

    localparam int unsigned N1   = 98;
    localparam int unsigned N2   = 10;
    localparam int unsigned W_K  = 4;
    localparam int unsigned A1_W = W_K + $clog2(N1);
    localparam int unsigned A2_W = W_K + $clog2(N2) + 1;
    localparam int unsigned I1_W = $clog2(N1);
    localparam int unsigned I2_W = $clog2(N2);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StL1   = 2'd1;
    localparam logic [1:0] StL2   = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    // w - 2**(W_K-1) in offset binary is just w with its MSB inverted.
    function automatic logic signed [W_K-1:0] ob_decode(input logic [W_K-1:0] w);
        return $signed({~w[W_K-1], w[W_K-2:0]});
    endfunction

endpackage

// File: rtl/mlp_acc_bank.sv
// N2 parallel layer-1 accumulators; every lane adds its own decoded weight when enabled.
module mlp_acc_bank
    import mlp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr,
    input  logic                   en,
    input  logic [N2*W_K-1:0]      w_col,
    input  logic [I2_W-1:0]        sel,
    output logic signed [A1_W-1:0] acc_sel
);

    logic signed [A1_W-1:0] acc_q [N2];
    logic signed [W_K-1:0]  dec_w [N2];
    logic signed [A1_W-1:0] add_w [N2];

    always_comb begin
        for (int j = 0; j < N2; j++) begin
            dec_w[j] = ob_decode(w_col[j*W_K +: W_K]);
            add_w[j] = {{(A1_W - W_K){dec_w[j][W_K-1]}}, dec_w[j]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int j = 0; j < N2; j++) acc_q[j] <= '0;
        end else if (clr) begin
            for (int j = 0; j < N2; j++) acc_q[j] <= '0;
        end else if (en) begin
            for (int j = 0; j < N2; j++) acc_q[j] <= acc_q[j] + add_w[j];
        end
    end

    assign acc_sel = acc_q[sel];

endmodule

// File: rtl/mlp_sched.sv
// Frame sequencer: layer 1 walks input pixels with all hidden lanes in parallel,
// layer 2 walks hidden neurons one per cycle, then holds the result until consumed.
module mlp_sched
    import mlp_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N1-1:0]     x_in,
    output logic [I1_W-1:0]   w1_idx,
    input  logic [N2*W_K-1:0] w1_col,
    output logic [I2_W-1:0]   w2_idx,
    input  logic [W_K-1:0]    w2_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              y_out,
    output logic [A2_W-1:0]   acc2_out,
    output logic              busy
);

    localparam logic [I1_W-1:0] I_LAST = I1_W'(N1 - 1);
    localparam logic [I2_W-1:0] N_LAST = I2_W'(N2 - 1);

    logic [1:0]             state_q;
    logic [N1-1:0]          x_q;
    logic [I1_W-1:0]        i_q;
    logic [I2_W-1:0]        n_q;
    logic signed [A2_W-1:0] acc2_q;

    logic                   accept;
    logic                   l1_en;
    logic                   h_n;
    logic signed [A1_W-1:0] acc1_n;
    logic signed [W_K-1:0]  w2_dec;
    logic signed [A2_W-1:0] w2_ext;

    assign accept = (state_q == StIdle) && in_valid;
    assign l1_en  = (state_q == StL1) && x_q[i_q];

    mlp_acc_bank u_acc_bank (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (accept),
        .en      (l1_en),
        .w_col   (w1_col),
        .sel     (n_q),
        .acc_sel (acc1_n)
    );

    // Strict signed "> 0": non-negative and non-zero.
    assign h_n    = !acc1_n[A1_W-1] && (acc1_n != '0);
    assign w2_dec = ob_decode(w2_val);
    assign w2_ext = {{(A2_W - W_K){w2_dec[W_K-1]}}, w2_dec};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            x_q     <= '0;
            i_q     <= '0;
            n_q     <= '0;
            acc2_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_q     <= x_in;
                        acc2_q  <= '0;
                        i_q     <= '0;
                        state_q <= StL1;
                    end
                end
                StL1: begin
                    if (i_q == I_LAST) begin
                        n_q     <= '0;
                        state_q <= StL2;
                    end else begin
                        i_q <= i_q + I1_W'(1);
                    end
                end
                StL2: begin
                    if (h_n) acc2_q <= acc2_q + w2_ext;
                    if (n_q == N_LAST) begin
                        state_q <= StDone;
                    end else begin
                        n_q <= n_q + I2_W'(1);
                    end
                end
                StDone: begin
                    if (out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign w1_idx    = i_q;
    assign w2_idx    = n_q;
    assign acc2_out  = acc2_q;
    assign y_out     = !acc2_q[A2_W-1] && (acc2_q != '0);

endmodule

// File: tb/tb_mlp_sched.sv
// Directed bench for mlp_sched with a behavioural MLP model feeding a result scoreboard.
module tb_mlp_sched;
    import mlp_pkg::*;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [N1-1:0]     x_in;
    logic [I1_W-1:0]   w1_idx;
    logic [N2*W_K-1:0] w1_col;
    logic [I2_W-1:0]   w2_idx;
    logic [W_K-1:0]    w2_val;
    logic              out_valid;
    logic              out_ready;
    logic              y_out;
    logic [A2_W-1:0]   acc2_out;
    logic              busy;

    logic [W_K-1:0] w1_even [N2];
    logic [W_K-1:0] w1_odd  [N2];
    logic [W_K-1:0] w2_tab  [N2];

    typedef struct {
        logic y;
        int   acc2;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    mlp_sched dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .w1_idx    (w1_idx),
        .w1_col    (w1_col),
        .w2_idx    (w2_idx),
        .w2_val    (w2_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .acc2_out  (acc2_out),
        .busy      (busy)
    );

    // Weight LUT stand-in: layer-1 weights depend on index parity so a wrong w1_idx shows up.
    always_comb begin
        for (int j = 0; j < N2; j++) begin
            w1_col[j*W_K +: W_K] = w1_idx[0] ? w1_odd[j] : w1_even[j];
        end
        w2_val = (w2_idx < I2_W'(N2)) ? w2_tab[w2_idx] : '0;
    end

    function automatic res_t model(input logic [N1-1:0] x);
        res_t r;
        int   a1;
        int   a2;
        a2 = 0;
        for (int j = 0; j < N2; j++) begin
            a1 = 0;
            for (int i = 0; i < N1; i++) begin
                if (x[i]) a1 += ((i % 2) == 1) ? int'(w1_odd[j]) - 8 : int'(w1_even[j]) - 8;
            end
            if (a1 > 0) a2 += int'(w2_tab[j]) - 8;
        end
        r.y    = (a2 > 0);
        r.acc2 = a2;
        return r;
    endfunction

    function automatic logic [N1-1:0] rand_frame();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[N1-1:0];
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_uniform(input logic [W_K-1:0] w1, input logic [W_K-1:0] w2);
        for (int j = 0; j < N2; j++) begin
            w1_even[j] = w1;
            w1_odd[j]  = w1;
            w2_tab[j]  = w2;
        end
    endtask

    task automatic set_random();
        for (int j = 0; j < N2; j++) begin
            w1_even[j] = W_K'($urandom_range(0, 15));
            w1_odd[j]  = W_K'($urandom_range(0, 15));
            w2_tab[j]  = W_K'($urandom_range(0, 15));
        end
    endtask

    task automatic start_frame(input logic [N1-1:0] x);
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = x;
        chk("in_ready_idle", int'(in_ready), 1);
        @(posedge clk);
        sb.push_back(model(x));
        @(negedge clk);
        in_valid = 1'b0;
        x_in     = ~x;
        chk("busy_after_accept", int'(busy), 1);
    endtask

    task automatic collect();
        int   lat = 0;
        int   bad = 0;
        res_t exp;
        while (!out_valid && lat < 300) begin
            if (in_ready || !busy) bad++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, int'(N1 + N2));
        chk("ready_busy_in_frame", bad, 0);
        if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk("y_out", int'(y_out), int'(exp.y));
            chk("acc2_out", int'($signed(acc2_out)), exp.acc2);
        end
    endtask

    task automatic release_done();
        @(posedge clk);
        @(negedge clk);
        chk("out_valid_drop", int'(out_valid), 0);
        chk("in_ready_back", int'(in_ready), 1);
        chk("busy_idle", int'(busy), 0);
    endtask

    logic [N1-1:0] xr;
    logic          y_hold;
    logic [A2_W-1:0] a_hold;
    res_t          dropped;
    int            n;
    int            ov_cnt;

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;
        set_uniform(4'd9, 4'd9);
        #3;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_acc2", int'(acc2_out), 0);
        chk("rst_w1_idx", int'(w1_idx), 0);
        chk("rst_w2_idx", int'(w2_idx), 0);
        @(negedge clk);
        rstn = 1'b1;

        // +1 everywhere, all pixels on: acc1 = 98, acc2 = 10.
        start_frame('1);
        collect();
        release_done();

        // No pixels: acc1 = 0 is not > 0, so nothing reaches layer 2.
        start_frame('0);
        collect();
        release_done();

        set_uniform(4'd7, 4'd9);
        start_frame('1);
        collect();
        release_done();

        // Most negative weight on every pixel: acc1 = -784.
        set_uniform(4'd0, 4'd9);
        start_frame('1);
        collect();
        release_done();

        set_uniform(4'd15, 4'd0);
        start_frame(N1'(1));
        collect();
        release_done();

        // Backpressure in DONE with a competing frame offered.
        set_uniform(4'd9, 4'd9);
        out_ready = 1'b0;
        start_frame('1);
        collect();
        y_hold   = y_out;
        a_hold   = acc2_out;
        set_random();
        xr       = rand_frame();
        in_valid = 1'b1;
        x_in     = xr;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_y_stable", int'(y_out), int'(y_hold));
            chk("bp_acc2_stable", int'(acc2_out), int'(a_hold));
            chk("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready), 1);
        @(posedge clk);
        sb.push_back(model(xr));
        @(negedge clk);
        in_valid = 1'b0;
        collect();
        release_done();

        // Abort mid layer 1.
        set_random();
        start_frame(rand_frame());
        n = 0;
        while (w1_idx != I1_W'(40) && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("reach_i40", int'(w1_idx), 40);
        #2;
        rstn = 1'b0;
        #1;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_w1_idx", int'(w1_idx), 0);
        chk("abort_w2_idx", int'(w2_idx), 0);
        chk("abort_acc2", int'(acc2_out), 0);
        chk("abort_y_out", int'(y_out), 0);
        if (sb.size() != 0) dropped = sb.pop_back();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("abort_release_ready", int'(in_ready), 1);
        ov_cnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        chk("abort_no_output", ov_cnt, 0);

        for (int f = 0; f < 3; f++) begin
            set_random();
            start_frame(rand_frame());
            collect();
            release_done();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
